mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported `mem` block between the CPU (port 0) and a second bus master (port 1), such as a serial program loader or debug DMA. It sits between the requesters and `mem`, forwarding exactly one requester's `rd`/`wr`/`addr`/`d` to memory and generating per-port `wait`. Grant is parked on the last owner, so a lone CPU sees no arbitration overhead. Port 1 may lock the grant for bounded bursts.

---
 rtl/mem_arbiter_if.sv | 14 +
 rtl/mem_arbiter.sv | 54 +++++
 tb/tb_mem_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/response bus between a master and a shared memory slave
interface mem_arbiter_if #(
  parameter int ABITS = 9,
  parameter int DBITS = 16
);
  logic rd;
  logic wr;
  logic [ABITS-1:0] addr;
  logic [DBITS-1:0] wdata;
  logic [DBITS-1:0] rdata;
  logic wait_req;
  modport master (output rd, wr, addr, wdata, input rdata, wait_req);
  modport slave (input rd, wr, addr, wdata, output rdata, wait_req);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: parked two-port arbiter for a single-ported memory with bounded port-1 burst lock
module mem_arbiter #(
  parameter int ABITS = 9,
  parameter int DBITS = 16,
  parameter int MAXBURST = 8
) (
  input  logic clk,
  input  logic rst_n,
  mem_arbiter_if.slave p0,
  mem_arbiter_if.slave p1,
  input  logic p1_lock,
  mem_arbiter_if.master mem,
  output logic [1:0] gnt
);
  localparam int CW = MAXBURST > 1 ? $clog2(MAXBURST) : 1;
  localparam logic [CW-1:0] BMAX = CW'(MAXBURST - 1);
  typedef enum logic [1:0] {IDLE = 2'b00, G0 = 2'b01, G1 = 2'b10} state_t;
  state_t state, next;
  logic [CW-1:0] bcnt;
  logic req0, req1, done0, done1;
  assign req0 = p0.rd | p0.wr;
  assign req1 = p1.rd | p1.wr;
  assign done0 = (state == G0) & req0 & ~mem.wait_req;
  assign done1 = (state == G1) & req1 & ~mem.wait_req;
  assign mem.rd = state == G0 ? p0.rd : state == G1 ? p1.rd : 1'b0;
  assign mem.wr = state == G0 ? p0.wr : state == G1 ? p1.wr : 1'b0;
  assign mem.addr = state == G0 ? p0.addr : state == G1 ? p1.addr : '0;
  assign mem.wdata = state == G0 ? p0.wdata : state == G1 ? p1.wdata : '0;
  assign p0.rdata = mem.rdata;
  assign p1.rdata = mem.rdata;
  assign p0.wait_req = req0 & ~done0;
  assign p1.wait_req = req1 & ~done1;
  assign gnt = state;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = req0 ? G0 : req1 ? G1 : IDLE;
      G0: next = (req1 & (~req0 | done0)) ? G1 : G0;
      G1: next = ~req1 ? (req0 ? G0 : G1)
               : (done1 & req0 & (~p1_lock | bcnt == BMAX)) ? G0 : G1;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      bcnt <= '0;
    end else begin
      state <= next;
      if (state == G1 && next != G1) bcnt <= '0;
      else if (done1 && bcnt != BMAX) bcnt <= bcnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of reset, parking, alternation, burst lock and stretched access
module tb_mem_arbiter;
  logic clk = 0;
  logic rst_n = 0;
  logic p1_lock = 0;
  logic [1:0] gnt;
  int n_cmp = 0;
  int n_err = 0;
  mem_arbiter_if #(.ABITS(9), .DBITS(16)) p0_if ();
  mem_arbiter_if #(.ABITS(9), .DBITS(16)) p1_if ();
  mem_arbiter_if #(.ABITS(9), .DBITS(16)) m_if ();
  mem_arbiter #(.ABITS(9), .DBITS(16), .MAXBURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .p0(p0_if), .p1(p1_if), .p1_lock(p1_lock), .mem(m_if), .gnt(gnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    p0_if.rd = 1; p0_if.wr = 0; p0_if.addr = 0; p0_if.wdata = 0;
    p1_if.rd = 1; p1_if.wr = 0; p1_if.addr = 9'h033; p1_if.wdata = 0;
    m_if.rdata = 0; m_if.wait_req = 0;
    repeat (3) tick();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_mem_rd", m_if.rd, 0);
    chk("rst_mem_addr", m_if.addr, 0);
    chk("rst_p0_wait", p0_if.wait_req, 1);
    chk("rst_p1_wait", p1_if.wait_req, 1);
    rst_n = 1;
    tick();
    chk("rel_gnt", gnt, 2'b01);
    rst_n = 0; p0_if.rd = 0; p1_if.rd = 0;
    tick();
    rst_n = 1;
    tick();
    p0_if.rd = 1; p0_if.addr = 9'h005; m_if.rdata = 16'h1234;
    #1;
    chk("cold_wait", p0_if.wait_req, 1);
    chk("cold_gnt", gnt, 2'b00);
    chk("cold_mem_rd", m_if.rd, 0);
    tick();
    chk("lone_gnt", gnt, 2'b01);
    chk("lone_mem_rd", m_if.rd, 1);
    chk("lone_addr", m_if.addr, 9'h005);
    chk("lone_wait", p0_if.wait_req, 0);
    chk("lone_rdata", p0_if.rdata, 16'h1234);
    for (int a = 6; a <= 9; a++) begin
      tick();
      p0_if.addr = 9'(a);
      #1;
      chk("b2b_addr", m_if.addr, a);
      chk("b2b_wait", p0_if.wait_req, 0);
      chk("b2b_gnt", gnt, 2'b01);
    end
    tick();
    p1_if.rd = 1;
    for (int i = 0; i < 4; i++) begin
      m_if.wait_req = 1;
      #1;
      chk("alt_gnt", gnt, i % 2 == 0 ? 2'b01 : 2'b10);
      chk("alt_w0_a", p0_if.wait_req, 1);
      chk("alt_w1_a", p1_if.wait_req, 1);
      tick();
      m_if.wait_req = 0;
      #1;
      chk("alt_gnt2", gnt, i % 2 == 0 ? 2'b01 : 2'b10);
      chk("alt_w0_b", p0_if.wait_req, i % 2 == 0 ? 1'b0 : 1'b1);
      chk("alt_w1_b", p1_if.wait_req, i % 2 == 0 ? 1'b1 : 1'b0);
      tick();
    end
    p1_lock = 1;
    #1;
    chk("lock_pre_gnt", gnt, 2'b01);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("lock_gnt", gnt, 2'b10);
      chk("lock_w1", p1_if.wait_req, 0);
      chk("lock_w0", p0_if.wait_req, 1);
      tick();
    end
    chk("lock_release", gnt, 2'b01);
    p0_if.rd = 0;
    #1;
    tick();
    for (int i = 0; i < 12; i++) begin
      chk("lone_lock_gnt", gnt, 2'b10);
      chk("lone_lock_w1", p1_if.wait_req, 0);
      tick();
    end
    p1_lock = 0; p1_if.rd = 0; p1_if.wr = 1; p1_if.addr = 9'h1FF; p1_if.wdata = 16'hBEEF;
    p0_if.rd = 1; m_if.wait_req = 1;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) m_if.wait_req = 0;
      #1;
      chk("str_wr", m_if.wr, 1);
      chk("str_addr", m_if.addr, 9'h1FF);
      chk("str_d", m_if.wdata, 16'hBEEF);
      chk("str_gnt", gnt, 2'b10);
      chk("str_w0", p0_if.wait_req, 1);
      chk("str_w1", p1_if.wait_req, i == 5 ? 1'b0 : 1'b1);
      tick();
    end
    p1_if.wr = 0;
    #1;
    chk("str_handover", gnt, 2'b01);
    chk("str_w0_done", p0_if.wait_req, 0);
    tick();
    p0_if.rd = 0;
    tick();
    chk("park_gnt", gnt, 2'b01);
    p1_if.rd = 1; p1_if.addr = 9'h0AA;
    #1;
    chk("park_w1", p1_if.wait_req, 1);
    chk("park_mem_rd", m_if.rd, 0);
    tick();
    chk("sw_gnt", gnt, 2'b10);
    chk("sw_mem_rd", m_if.rd, 1);
    chk("sw_addr", m_if.addr, 9'h0AA);
    chk("sw_w1", p1_if.wait_req, 0);
    m_if.wait_req = 1;
    rst_n = 0;
    tick();
    chk("abort_gnt", gnt, 2'b00);
    chk("abort_mem_rd", m_if.rd, 0);
    chk("abort_w1", p1_if.wait_req, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
